mem_xfer_ctrl: RTL and testbench

- Sequencer for block copies between two word-addressed memories (source and destination).
- Sits above the address-counter datapath. Accepts a start command carrying source base, destination base and word count.
- Issues one read per word, captures the returned data, then writes it to the destination. Signals completion with a one-cycle done pulse.
- Supports abort.

---
 rtl/mem_xfer_ctrl.sv | 170 +++++++++++++++++
 tb/tb_mem_xfer_ctrl.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_xfer_ctrl.sv
// Block-copy sequencer: reads one source word, waits RD_LAT cycles for the data,
// writes it to the destination, and repeats until the word count is exhausted or aborted.
module mem_xfer_ctrl #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rstor,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_base,
    input  logic [ADDR_W-1:0] dst_base,
    input  logic [ADDR_W:0]   len,
    input  logic              abort,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic [ADDR_W:0]   xfer_cnt
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_WAIT  = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [ADDR_W-1:0] A_ONE     = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   C_ONE     = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   C_ZERO    = {(ADDR_W+1){1'b0}};
    localparam logic [2:0]        WAIT_LAST = 3'(RD_LAT - 1);

    state_t              r_state;
    logic [ADDR_W-1:0]   r_src;
    logic [ADDR_W-1:0]   r_dst;
    logic [ADDR_W:0]     r_rem;
    logic [ADDR_W:0]     r_cnt;
    logic [DATA_W-1:0]   r_data;
    logic [2:0]          r_wait;
    logic                r_rd_en;
    logic [ADDR_W-1:0]   r_rd_addr;
    logic                r_wr_en;
    logic [ADDR_W-1:0]   r_wr_addr;
    logic                r_busy;
    logic                r_done;
    logic                r_aborted;

    logic [ADDR_W-1:0]   w_src_nxt;
    logic [ADDR_W-1:0]   w_dst_nxt;
    logic                w_last;

    assign w_src_nxt = r_src + A_ONE;
    assign w_dst_nxt = r_dst + A_ONE;
    assign w_last    = (r_rem == C_ONE);

    // Sequencer FSM; every output is set on the edge entering the state that owns it.
    always_ff @(posedge clk or posedge rstor) begin
        if (rstor) begin
            r_state   <= S_IDLE;
            r_src     <= {ADDR_W{1'b0}};
            r_dst     <= {ADDR_W{1'b0}};
            r_rem     <= C_ZERO;
            r_cnt     <= C_ZERO;
            r_data    <= {DATA_W{1'b0}};
            r_wait    <= 3'd0;
            r_rd_en   <= 1'b0;
            r_rd_addr <= {ADDR_W{1'b0}};
            r_wr_en   <= 1'b0;
            r_wr_addr <= {ADDR_W{1'b0}};
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_aborted <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_src     <= src_base;
                        r_dst     <= dst_base;
                        r_rem     <= len;
                        r_cnt     <= C_ZERO;
                        r_aborted <= 1'b0;
                        if (len == C_ZERO) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state   <= S_READ;
                            r_rd_en   <= 1'b1;
                            r_rd_addr <= src_base;
                            r_busy    <= 1'b1;
                        end
                    end
                end
                S_READ: begin
                    r_rd_en <= 1'b0;
                    if (abort) begin
                        r_state   <= S_DONE;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                        r_aborted <= 1'b1;
                    end else begin
                        r_state <= S_WAIT;
                        r_wait  <= 3'd0;
                    end
                end
                S_WAIT: begin
                    // An abort here drops the in-flight read; nothing is written.
                    if (abort) begin
                        r_state   <= S_DONE;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                        r_aborted <= 1'b1;
                    end else if (r_wait == WAIT_LAST) begin
                        r_data    <= rd_data;
                        r_state   <= S_WRITE;
                        r_wr_en   <= 1'b1;
                        r_wr_addr <= r_dst;
                    end else begin
                        r_wait <= r_wait + 3'd1;
                    end
                end
                S_WRITE: begin
                    r_wr_en <= 1'b0;
                    r_cnt   <= r_cnt + C_ONE;
                    r_rem   <= r_rem - C_ONE;
                    r_src   <= w_src_nxt;
                    r_dst   <= w_dst_nxt;
                    if (abort || w_last) begin
                        r_state   <= S_DONE;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                        r_aborted <= abort;
                    end else begin
                        r_state   <= S_READ;
                        r_rd_en   <= 1'b1;
                        r_rd_addr <= w_src_nxt;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_rd_en <= 1'b0;
                    r_wr_en <= 1'b0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign rd_en    = r_rd_en;
    assign rd_addr  = r_rd_addr;
    assign wr_en    = r_wr_en;
    assign wr_addr  = r_wr_addr;
    assign wr_data  = r_data;
    assign busy     = r_busy;
    assign done     = r_done;
    assign aborted  = r_aborted;
    assign xfer_cnt = r_cnt;

endmodule

// File: tb/tb_mem_xfer_ctrl.sv
// Scoreboard bench for mem_xfer_ctrl: one RD_LAT=1 instance (a) and one RD_LAT=3 instance (b),
// each with its own source-memory model; a single monitor checks reads, writes and done records.
module tb_mem_xfer_ctrl;

    typedef struct packed {
        logic [5:0]  cnt;
        logic        ab;
        logic [15:0] busy;
    } done_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstor;

    logic       start_a, abort_a, rd_en_a, wr_en_a, busy_a, done_a, aborted_a;
    logic [4:0] src_a, dst_a, rd_addr_a, wr_addr_a;
    logic [5:0] len_a, xfer_cnt_a;
    logic [7:0] rd_data_a, wr_data_a;

    logic       start_b, abort_b, rd_en_b, wr_en_b, busy_b, done_b, aborted_b;
    logic [4:0] src_b, dst_b, rd_addr_b, wr_addr_b;
    logic [5:0] len_b, xfer_cnt_b;
    logic [7:0] rd_data_b, wr_data_b;

    int checks = 0;
    int errors = 0;
    int n_timeouts = 0;
    logic end_req = 1'b0;
    logic end_ack = 1'b0;

    logic [4:0]  q_rd_a[$];
    logic [12:0] q_wr_a[$];
    done_t       q_dn_a[$];
    logic [4:0]  q_rd_b[$];
    logic [12:0] q_wr_b[$];
    done_t       q_dn_b[$];

    function automatic logic [7:0] mem_val(input logic [4:0] a);
        return {a, 3'b101} ^ 8'h3C;
    endfunction

    mem_xfer_ctrl #(.ADDR_W(5), .DATA_W(8), .RD_LAT(1)) u_dut_a (
        .clk(clk), .rstor(rstor), .start(start_a), .src_base(src_a), .dst_base(dst_a),
        .len(len_a), .abort(abort_a), .rd_en(rd_en_a), .rd_addr(rd_addr_a),
        .rd_data(rd_data_a), .wr_en(wr_en_a), .wr_addr(wr_addr_a), .wr_data(wr_data_a),
        .busy(busy_a), .done(done_a), .aborted(aborted_a), .xfer_cnt(xfer_cnt_a)
    );

    mem_xfer_ctrl #(.ADDR_W(5), .DATA_W(8), .RD_LAT(3)) u_dut_b (
        .clk(clk), .rstor(rstor), .start(start_b), .src_base(src_b), .dst_base(dst_b),
        .len(len_b), .abort(abort_b), .rd_en(rd_en_b), .rd_addr(rd_addr_b),
        .rd_data(rd_data_b), .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b),
        .busy(busy_b), .done(done_b), .aborted(aborted_b), .xfer_cnt(xfer_cnt_b)
    );

    // Source memories: data for a read appears exactly RD_LAT cycles after rd_en, for one cycle.
    logic [5:0] pipe_a, pipe_b0, pipe_b1, pipe_b2;
    always @(posedge clk or posedge rstor) begin
        if (rstor) begin
            pipe_a  <= 6'd0;
            pipe_b0 <= 6'd0;
            pipe_b1 <= 6'd0;
            pipe_b2 <= 6'd0;
        end else begin
            pipe_a  <= {rd_en_a, rd_addr_a};
            pipe_b0 <= {rd_en_b, rd_addr_b};
            pipe_b1 <= pipe_b0;
            pipe_b2 <= pipe_b1;
        end
    end
    assign rd_data_a = pipe_a[5]  ? mem_val(pipe_a[4:0])  : 8'h00;
    assign rd_data_b = pipe_b2[5] ? mem_val(pipe_b2[4:0]) : 8'h00;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic miss(input string name, input logic [63:0] act);
        checks++;
        errors++;
        $display("FAIL %s: unexpected event, value %0h, nothing expected at %0t", name, act, $time);
    endtask

    // Monitor: sole owner of checks/errors; samples on the falling edge.
    int lat_a = 0, lat_b = 0, bsy_a = 0, bsy_b = 0;
    logic lon_a = 1'b0, lon_b = 1'b0;
    initial begin
        logic [4:0]  e5;
        logic [12:0] e13;
        done_t       ed;
        forever begin
            @(negedge clk);
            if (rstor) begin
                chk("reset_outs_a", 64'({rd_en_a, rd_addr_a, wr_en_a, wr_addr_a, wr_data_a,
                                         busy_a, done_a, aborted_a, xfer_cnt_a}), 64'd0);
                chk("reset_outs_b", 64'({rd_en_b, rd_addr_b, wr_en_b, wr_addr_b, wr_data_b,
                                         busy_b, done_b, aborted_b, xfer_cnt_b}), 64'd0);
                lon_a = 1'b0; lon_b = 1'b0; bsy_a = 0; bsy_b = 0;
            end else begin
                if (rd_en_a || wr_en_a) chk("rd_wr_excl_a", 64'(rd_en_a & wr_en_a), 64'd0);
                if (rd_en_a) begin
                    if (q_rd_a.size() == 0) miss("rd_a", 64'(rd_addr_a));
                    else begin e5 = q_rd_a.pop_front(); chk("rd_addr_a", 64'(rd_addr_a), 64'(e5)); end
                end
                if (wr_en_a) begin
                    if (q_wr_a.size() == 0) miss("wr_a", 64'({wr_addr_a, wr_data_a}));
                    else begin e13 = q_wr_a.pop_front(); chk("wr_addr_data_a", 64'({wr_addr_a, wr_data_a}), 64'(e13)); end
                end
                if (lon_a) lat_a++;
                if (busy_a) bsy_a++;
                if (done_a) begin
                    if (q_dn_a.size() == 0) miss("done_a", 64'(xfer_cnt_a));
                    else begin
                        ed = q_dn_a.pop_front();
                        chk("xfer_cnt_a", 64'(xfer_cnt_a), 64'(ed.cnt));
                        chk("aborted_a", 64'(aborted_a), 64'(ed.ab));
                        chk("busy_cycles_a", 64'(bsy_a), 64'(ed.busy));
                        chk("done_latency_a", 64'(lat_a), 64'(ed.busy) + 64'd1);
                    end
                    lon_a = 1'b0; bsy_a = 0;
                end
                if (start_a && !busy_a && !done_a) begin lon_a = 1'b1; lat_a = 0; end

                if (rd_en_b || wr_en_b) chk("rd_wr_excl_b", 64'(rd_en_b & wr_en_b), 64'd0);
                if (rd_en_b) begin
                    if (q_rd_b.size() == 0) miss("rd_b", 64'(rd_addr_b));
                    else begin e5 = q_rd_b.pop_front(); chk("rd_addr_b", 64'(rd_addr_b), 64'(e5)); end
                end
                if (wr_en_b) begin
                    if (q_wr_b.size() == 0) miss("wr_b", 64'({wr_addr_b, wr_data_b}));
                    else begin e13 = q_wr_b.pop_front(); chk("wr_addr_data_b", 64'({wr_addr_b, wr_data_b}), 64'(e13)); end
                end
                if (lon_b) lat_b++;
                if (busy_b) bsy_b++;
                if (done_b) begin
                    if (q_dn_b.size() == 0) miss("done_b", 64'(xfer_cnt_b));
                    else begin
                        ed = q_dn_b.pop_front();
                        chk("xfer_cnt_b", 64'(xfer_cnt_b), 64'(ed.cnt));
                        chk("aborted_b", 64'(aborted_b), 64'(ed.ab));
                        chk("busy_cycles_b", 64'(bsy_b), 64'(ed.busy));
                        chk("done_latency_b", 64'(lat_b), 64'(ed.busy) + 64'd1);
                    end
                    lon_b = 1'b0; bsy_b = 0;
                end
                if (start_b && !busy_b && !done_b) begin lon_b = 1'b1; lat_b = 0; end
            end
            if (end_req && !end_ack) begin
                chk("leftover_reads", 64'(q_rd_a.size() + q_rd_b.size()), 64'd0);
                chk("leftover_writes", 64'(q_wr_a.size() + q_wr_b.size()), 64'd0);
                chk("leftover_dones", 64'(q_dn_a.size() + q_dn_b.size()), 64'd0);
                chk("done_timeouts", 64'(n_timeouts), 64'd0);
                end_ack = 1'b1;
            end
        end
    end

    task automatic expect_words(input int inst, input logic [4:0] s, input logic [4:0] d,
                                input int n_rd, input int n_wr);
        logic [4:0] a, w;
        for (int i = 0; i < n_rd; i++) begin
            a = s + 5'(i);
            if (inst == 0) q_rd_a.push_back(a); else q_rd_b.push_back(a);
        end
        for (int i = 0; i < n_wr; i++) begin
            a = s + 5'(i);
            w = d + 5'(i);
            if (inst == 0) q_wr_a.push_back({w, mem_val(a)}); else q_wr_b.push_back({w, mem_val(a)});
        end
    endtask

    task automatic expect_done(input int inst, input logic [5:0] c, input logic ab, input logic [15:0] b);
        done_t r;
        r.cnt = c; r.ab = ab; r.busy = b;
        if (inst == 0) q_dn_a.push_back(r); else q_dn_b.push_back(r);
    endtask

    // One-cycle start pulse; returns #1 after the edge that samples it.
    task automatic go(input int inst, input logic [4:0] s, input logic [4:0] d, input logic [5:0] n);
        @(posedge clk); #1;
        if (inst == 0) begin src_a = s; dst_a = d; len_a = n; start_a = 1'b1; end
        else begin src_b = s; dst_b = d; len_b = n; start_b = 1'b1; end
        @(posedge clk); #1;
        if (inst == 0) start_a = 1'b0; else start_b = 1'b0;
    endtask

    task automatic wait_done(input int inst, input int budget);
        for (int i = 0; i < budget; i++) begin
            if ((inst == 0) ? done_a : done_b) return;
            @(posedge clk); #1;
        end
        n_timeouts++;
        $display("FAIL done_wait inst %0d: no done within %0d cycles, required one", inst, budget);
    endtask

    initial begin
        rstor = 1'b1;
        start_a = 1'b0; abort_a = 1'b0; src_a = 5'd0; dst_a = 5'd0; len_a = 6'd0;
        start_b = 1'b0; abort_b = 1'b0; src_b = 5'd0; dst_b = 5'd0; len_b = 6'd0;
        repeat (3) @(posedge clk);
        #1 rstor = 1'b0;

        // Reset during the WAIT of word 1: only the first read may have happened.
        expect_words(0, 5'd0, 5'd8, 1, 0);
        go(0, 5'd0, 5'd8, 6'd8);
        @(posedge clk); #2 rstor = 1'b1;
        repeat (2) @(posedge clk);
        #1 rstor = 1'b0;

        expect_words(0, 5'd3, 5'd20, 4, 4);
        expect_done(0, 6'd4, 1'b0, 16'd12);
        go(0, 5'd3, 5'd20, 6'd4);
        wait_done(0, 40);

        expect_words(0, 5'd30, 5'd0, 3, 3);
        expect_done(0, 6'd3, 1'b0, 16'd9);
        go(0, 5'd30, 5'd0, 6'd3);
        wait_done(0, 40);

        expect_done(0, 6'd0, 1'b0, 16'd0);
        go(0, 5'd9, 5'd9, 6'd0);
        wait_done(0, 10);

        // Abort sampled at the edge ending the WAIT of word 3.
        expect_words(0, 5'd1, 5'd16, 3, 2);
        expect_done(0, 6'd2, 1'b1, 16'd8);
        go(0, 5'd1, 5'd16, 6'd10);
        repeat (7) @(posedge clk);
        #1 abort_a = 1'b1;
        @(posedge clk); #1 abort_a = 1'b0;
        wait_done(0, 20);

        expect_words(0, 5'd2, 5'd2, 1, 1);
        expect_done(0, 6'd1, 1'b0, 16'd3);
        go(0, 5'd2, 5'd2, 6'd1);
        wait_done(0, 20);

        // Abort coinciding with the final WRITE.
        expect_words(0, 5'd12, 5'd25, 2, 2);
        expect_done(0, 6'd2, 1'b1, 16'd6);
        go(0, 5'd12, 5'd25, 6'd2);
        repeat (5) @(posedge clk);
        #1 abort_a = 1'b1;
        @(posedge clk); #1 abort_a = 1'b0;
        wait_done(0, 20);

        expect_words(0, 5'd7, 5'd9, 32, 32);
        expect_done(0, 6'd32, 1'b0, 16'd96);
        go(0, 5'd7, 5'd9, 6'd32);
        wait_done(0, 200);

        // RD_LAT=3 instance, with start pulses during busy that must be ignored.
        expect_words(1, 5'd10, 5'd5, 2, 2);
        expect_done(1, 6'd2, 1'b0, 16'd10);
        go(1, 5'd10, 5'd5, 6'd2);
        repeat (2) @(posedge clk);
        #1 src_b = 5'd0; len_b = 6'd5; start_b = 1'b1;
        @(posedge clk); #1 start_b = 1'b0;
        repeat (3) @(posedge clk);
        #1 start_b = 1'b1;
        @(posedge clk); #1 start_b = 1'b0;
        wait_done(1, 30);

        repeat (3) @(posedge clk);
        end_req = 1'b1;
        for (int i = 0; i < 5 && !end_ack; i++) @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
